// File: rtl/gcd_if.sv
// Operand/result handshake bundle for gcd_engine.
// The producer/consumer side uses master; the engine uses slave.
interface gcd_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x0;
    logic [W-1:0]  y0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  gcd;
    logic [CW-1:0] iters;
    logic          zero_err;

    modport master (
        output in_valid, x0, y0, out_ready,
        input  in_ready, out_valid, gcd, iters, zero_err
    );

    modport slave (
        input  in_valid, x0, y0, out_ready,
        output in_ready, out_valid, gcd, iters, zero_err
    );
endinterface

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready handshakes and a saturating step count.
// Define GCD_STEIN_EN to iterate with the binary (Stein) algorithm instead of subtraction.
module gcd_engine #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    gcd_if.slave   bus,
    output logic   busy
);
    localparam logic [CW-1:0] ITER_MAX = '1;
`ifdef GCD_STEIN_EN
    localparam int unsigned KW = $clog2(W) + 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  gcd_q, gcd_d;
    logic [CW-1:0] iters_q, iters_d;
    logic [CW-1:0] iters_inc;
    logic          zero_err_q, zero_err_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
`ifdef GCD_STEIN_EN
    logic [KW-1:0] k_q, k_d;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        gcd_d      = gcd_q;
        iters_d    = iters_q;
        zero_err_d = zero_err_q;
`ifdef GCD_STEIN_EN
        k_d        = k_q;
`endif
        iters_inc  = (iters_q == ITER_MAX) ? iters_q : iters_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d        = bus.x0;
                    y_d        = bus.y0;
                    iters_d    = '0;
                    zero_err_d = 1'b0;
`ifdef GCD_STEIN_EN
                    k_d        = '0;
`endif
                    if ((bus.x0 == '0) || (bus.y0 == '0)) begin
                        gcd_d      = bus.x0 | bus.y0;
                        zero_err_d = (bus.x0 == '0) && (bus.y0 == '0);
                        state_d    = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
`ifdef GCD_STEIN_EN
                // Stein: one action per cycle; common factors of two tracked in k
                if (x_q == y_q) begin
                    gcd_d   = x_q << k_q;
                    state_d = DONE;
                end else begin
                    iters_d = iters_inc;
                    if (!x_q[0] && !y_q[0]) begin
                        x_d = x_q >> 1;
                        y_d = y_q >> 1;
                        k_d = k_q + KW'(1);
                    end else if (!x_q[0]) begin
                        x_d = x_q >> 1;
                    end else if (!y_q[0]) begin
                        y_d = y_q >> 1;
                    end else if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        y_d = y_q - x_q;
                    end
                end
`else
                if (x_q == y_q) begin
                    gcd_d   = x_q;
                    state_d = DONE;
                end else if (x_q > y_q) begin
                    x_d     = x_q - y_q;
                    iters_d = iters_inc;
                end else begin
                    y_d     = y_q - x_q;
                    iters_d = iters_inc;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            gcd_q       <= '0;
            iters_q     <= '0;
            zero_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GCD_STEIN_EN
            k_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            gcd_q       <= gcd_d;
            iters_q     <= iters_d;
            zero_err_q  <= zero_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef GCD_STEIN_EN
            k_q         <= k_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.gcd       = gcd_q;
    assign bus.iters     = iters_q;
    assign bus.zero_err  = zero_err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine (W=8, CW=4): directed table, corner sequences, random pairs.
// Builds with or without GCD_STEIN_EN; the reference model follows the same macro.
module tb_gcd_engine;
    localparam int unsigned W   = 8;
    localparam int unsigned CW  = 4;
    localparam int          SAT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    gcd_if #(.W(W), .CW(CW)) bus ();

    gcd_engine #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: Euclid by remainder for the value
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Reference step count for nonzero operands
    function automatic int ref_steps(input int a, input int b);
        int s;
        s = 0;
        if (a == 0 || b == 0) return 0;
`ifdef GCD_STEIN_EN
        while (a != b) begin
            s++;
            if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
            else if (a % 2 == 0) a = a / 2;
            else if (b % 2 == 0) b = b / 2;
            else if (a > b) a = a - b;
            else b = b - a;
        end
`else
        // Repeated subtraction takes sum of Euclid quotients, minus the final one-step equality
        begin
            int t;
            while (b != 0) begin
                s += a / b;
                t = a % b;
                a = b;
                b = t;
            end
            s = s - 1;
        end
`endif
        return s;
    endfunction

    function automatic int ref_iters(input int a, input int b);
        int s;
        s = ref_steps(a, b);
        return (s > SAT) ? SAT : s;
    endfunction

    function automatic int ref_lat(input int a, input int b);
        if (a == 0 || b == 0) return 1;
        return ref_steps(a, b) + 2;
    endfunction

    // Protocol monitor: no result without a job, one result per job
    int  n_acc = 0, n_res = 0, n_abort = 0, n_spur = 0;
    bit  pending = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            if (pending) n_abort++;
            pending = 0;
        end else begin
            if (bus.out_valid && !pending) n_spur++;
            if (bus.in_valid && bus.in_ready) begin n_acc++; pending = 1; end
            if (bus.out_valid && bus.out_ready) begin n_res++; pending = 0; end
        end
    end

    // Called at a negedge; returns at a negedge after the result handshake
    task automatic run_job(input int x, input int y, input int hold,
                           output int g, output int it, output int ze, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.x0 = W'(x);
        bus.y0 = W'(y);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x0 = W'($urandom);
        bus.y0 = W'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        g  = int'(bus.gcd);
        it = int'(bus.iters);
        ze = int'(bus.zero_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_gcd", int'(bus.gcd), g);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        int x, y, g, ze;
        int it_sub, lat_sub, it_st, lat_st;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int g, it, ze, lat, x, y, hold, e_it, e_lat;

        vecs[0] = '{x:12,  y:8,   g:4,  ze:0, it_sub:2,  lat_sub:4,   it_st:5,  lat_st:7};
        vecs[1] = '{x:0,   y:9,   g:9,  ze:0, it_sub:0,  lat_sub:1,   it_st:0,  lat_st:1};
        vecs[2] = '{x:0,   y:0,   g:0,  ze:1, it_sub:0,  lat_sub:1,   it_st:0,  lat_st:1};
        vecs[3] = '{x:9,   y:0,   g:9,  ze:0, it_sub:0,  lat_sub:1,   it_st:0,  lat_st:1};
        vecs[4] = '{x:7,   y:7,   g:7,  ze:0, it_sub:0,  lat_sub:2,   it_st:0,  lat_st:2};
        vecs[5] = '{x:255, y:1,   g:1,  ze:0, it_sub:15, lat_sub:256, it_st:14, lat_st:16};
        vecs[6] = '{x:21,  y:14,  g:7,  ze:0, it_sub:2,  lat_sub:4,   it_st:3,  lat_st:5};
        vecs[7] = '{x:128, y:64,  g:64, ze:0, it_sub:1,  lat_sub:3,   it_st:7,  lat_st:9};
        vecs[8] = '{x:5,   y:5,   g:5,  ze:0, it_sub:0,  lat_sub:2,   it_st:0,  lat_st:2};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x0        = '0;
        bus.y0        = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_busy",      int'(busy),          0);
        check("rst_gcd",       int'(bus.gcd),       0);
        check("rst_iters",     int'(bus.iters),     0);
        check("rst_zero_err",  int'(bus.zero_err),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
`ifdef GCD_STEIN_EN
            e_it = vecs[i].it_st;  e_lat = vecs[i].lat_st;
`else
            e_it = vecs[i].it_sub; e_lat = vecs[i].lat_sub;
`endif
            run_job(vecs[i].x, vecs[i].y, 1, g, it, ze, lat);
            check("vec_gcd",   g,   vecs[i].g);
            check("vec_zero",  ze,  vecs[i].ze);
            check("vec_iters", it,  e_it);
            check("vec_lat",   lat, e_lat);
            check("vec_idle_after", int'(bus.out_valid), 0);
        end

        // Reset mid-RUN aborts the job
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b1; bus.x0 = W'(200); bus.y0 = W'(3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy", int'(busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_gcd",       int'(bus.gcd),       0);
        check("abort_iters",     int'(bus.iters),     0);
        check("abort_in_ready",  int'(bus.in_ready),  1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        check("post_rst_busy",     int'(busy),         0);

        // Backpressure, ignored in_valid while busy, then back-to-back accept
        bus.in_valid = 1'b1; bus.x0 = W'(21); bus.y0 = W'(14);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 400) begin @(negedge clk); lat++; end
        check("bp_lat", lat, ref_lat(21, 14));
        bus.in_valid = 1'b1; bus.x0 = W'(5); bus.y0 = W'(5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_gcd",       int'(bus.gcd),       7);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_in_ready",  int'(bus.in_ready),  0);
        end
        check("bp_iters", int'(bus.iters), ref_iters(21, 14));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b_out_valid_drop", int'(bus.out_valid), 0);
        check("b2b_in_ready",       int'(bus.in_ready),  1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 400) begin @(negedge clk); lat++; end
        check("b2b_lat",   lat,                 2);
        check("b2b_gcd",   int'(bus.gcd),       5);
        check("b2b_iters", int'(bus.iters),     0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Random pairs against the reference model
        for (int i = 0; i < 1000; i++) begin
            x    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            y    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            hold = int'($urandom_range(0, 2));
            run_job(x, y, hold, g, it, ze, lat);
            check("rnd_gcd",   g,   ref_gcd(x, y));
            check("rnd_zero",  ze,  (x == 0 && y == 0) ? 1 : 0);
            check("rnd_iters", it,  ref_iters(x, y));
            check("rnd_lat",   lat, ref_lat(x, y));
        end

        @(negedge clk);
        check("spurious_results", n_spur, 0);
        check("one_result_per_job", n_res + n_abort, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
